// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: single-access controller for an asynchronous 4096x4 RAM with a
// shared bidirectional data bus.
// Each access runs through four phases:
// - IDLE: the controller accepts a request.
// - SETUP: the address and write data settle on the bus.
// - STROBE: chip select is held for STROBE_CYCLES cycles.
// - HOLD: the bus stays stable while chip select is released and rsp_valid pulses.
//
// Ports
//   clk        : single clock, rising edge
//   reset_n    : synchronous active-low reset
//   req_valid  : core presents a request
//   req_ready  : controller is idle and can accept a request
//   req_we     : 1 = write, 0 = read
//   req_addr   : 12-bit word address
//   req_wdata  : write nibble
//   rsp_valid  : one-cycle completion pulse
//   rsp_rdata  : last read nibble, held until the next read completes
//   ram_add    : RAM address
//   ram_we     : RAM write enable, active-high
//   ram_cs     : RAM chip select, active-high
//   ram_data   : shared RAM data bus, driven only during write phases
module ram_bus_ctrl #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [3:0]  req_wdata,
  output logic        rsp_valid,
  output logic [3:0]  rsp_rdata,
  output logic [11:0] ram_add,
  output logic        ram_we,
  output logic        ram_cs,
  inout  wire  [3:0]  ram_data
);

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       we_lat;
  logic [3:0] wdata_lat;
  logic       handshake;
  logic       drive;

  // Next-state and phase outputs
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    rsp_valid  = 1'b0;
    drive      = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        // Ready is masked during reset so no request appears accepted
        req_ready = reset_n;
        handshake = req_valid && reset_n;
        if (handshake) state_next = SETUP;
      end
      SETUP: begin
        drive      = we_lat;
        state_next = STROBE;
      end
      STROBE: begin
        ram_cs = 1'b1;
        ram_we = we_lat;
        drive  = we_lat;
        if (cnt == 4'd0) state_next = HOLD;
      end
      HOLD: begin
        // Write data stays on the bus one cycle past chip select for hold time
        drive      = we_lat;
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_data = drive ? wdata_lat : 4'bzzzz;

  // Control state, address register and read capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ram_add   <= 12'd0;
      rsp_rdata <= 4'd0;
    end else begin
      state <= state_next;
      if (handshake) ram_add <= req_addr;
      if (state == SETUP) begin
        cnt <= CNT_LOAD;
      end else if (state == STROBE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Sample read data on the edge that ends the final strobe cycle
      if (state == STROBE && cnt == 4'd0 && !we_lat) rsp_rdata <= ram_data;
    end
  end

  // Request latch: only ever consumed while an access is in flight
  always_ff @(posedge clk) begin
    if (handshake) begin
      we_lat    <= req_we;
      wdata_lat <= req_wdata;
    end
  end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
module tb_ram_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n   [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [11:0] req_addr  [2];
  logic [3:0]  req_wdata [2];
  logic        rsp_valid [2];
  logic [3:0]  rsp_rdata [2];
  logic [11:0] ram_add   [2];
  logic        ram_we    [2];
  logic        ram_cs    [2];
  wire  [3:0]  bus0;
  wire  [3:0]  bus1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ram_bus_ctrl #(.STROBE_CYCLES(1)) dut0 (
    .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .ram_add(ram_add[0]),
    .ram_we(ram_we[0]), .ram_cs(ram_cs[0]), .ram_data(bus0));

  ram_bus_ctrl #(.STROBE_CYCLES(4)) dut1 (
    .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .ram_add(ram_add[1]),
    .ram_we(ram_we[1]), .ram_cs(ram_cs[1]), .ram_data(bus1));

  // RAM devices. When neither the RAM nor (per the model) the controller should
  // drive, the bench drives 0, so a controller driving out of turn shows up.
  logic [3:0] mem0 [4096];
  logic [3:0] mem1 [4096];
  assign bus0 = (ram_cs[0] && !ram_we[0]) ? mem0[ram_add[0]] : (mdl[0].drv ? 4'bzzzz : 4'h0);
  assign bus1 = (ram_cs[1] && !ram_we[1]) ? mem1[ram_add[1]] : (mdl[1].drv ? 4'bzzzz : 4'h0);
  always @(posedge clk) begin
    if (ram_cs[0] && ram_we[0]) mem0[ram_add[0]] <= bus0;
    if (ram_cs[1] && ram_we[1]) mem1[ram_add[1]] <= bus1;
  end
  initial for (int i = 0; i < 4096; i++) begin mem0[i] = 4'h0; mem1[i] = 4'h0; end

  task automatic check(input string nm, input int g, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, g, act, exp, $time);
    end
  endtask

  // Transaction-level model: an access accepted at edge T occupies cycles
  // T+1 .. T+2+S; offset 1 is setup, 2..S+1 strobe, S+2 the completion cycle.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int S = (g == 0) ? 1 : 4;
    int          phase = 0;
    bit          mv = 1'b0;
    logic        mwe = 1'b0;
    logic [11:0] maddr = 12'd0;
    logic [3:0]  mwd = 4'd0;
    logic [11:0] madd = 12'd0;
    logic [3:0]  mrd = 4'd0;
    logic [3:0]  refm [4096];
    int          rcnt = 0;
    logic        prev_cs = 1'b0;
    logic [11:0] prev_add = 12'd0;
    logic [3:0]  prev_bus = 4'd0;
    logic        drv;
    logic [3:0]  bus_now;
    logic        cs_e;
    logic [3:0]  bus_e;

    initial for (int i = 0; i < 4096; i++) refm[i] = 4'h0;

    assign drv     = mv && mwe && (phase != 0);
    assign bus_now = (g == 0) ? bus0 : bus1;

    always @(posedge clk) begin
      if (!reset_n[g]) begin
        phase = 0; madd = 12'd0; mrd = 4'd0; mv = 1'b1;
      end else if (phase == 0) begin
        if (req_valid[g]) begin
          phase = 1; mwe = req_we[g]; maddr = req_addr[g]; mwd = req_wdata[g]; madd = req_addr[g];
        end
      end else if (phase == S + 1) begin
        if (mwe) refm[maddr] = mwd;
        else     mrd = refm[maddr];
        phase = S + 2;
      end else if (phase == S + 2) begin
        phase = 0;
      end else begin
        phase = phase + 1;
      end
    end

    always @(negedge clk) begin
      if (mv) begin
        cs_e  = (phase >= 2) && (phase <= S + 1);
        bus_e = (mwe && phase != 0) ? mwd : (cs_e ? refm[maddr] : 4'h0);
        check("req_ready", g, 16'(req_ready[g]), 16'(phase == 0 && reset_n[g]));
        check("ram_cs",    g, 16'(ram_cs[g]),    16'(cs_e));
        check("ram_we",    g, 16'(ram_we[g]),    16'(cs_e && mwe));
        check("rsp_valid", g, 16'(rsp_valid[g]), 16'(phase == S + 2));
        check("ram_add",   g, 16'(ram_add[g]),   16'(madd));
        check("rsp_rdata", g, 16'(rsp_rdata[g]), 16'(mrd));
        check("ram_data",  g, 16'(bus_now),      16'(bus_e));
        check("we_wo_cs",  g, 16'(ram_we[g] && !ram_cs[g]), 16'd0);
        if (ram_cs[g] && prev_cs) begin
          check("add_stable", g, 16'(ram_add[g]), 16'(prev_add));
          check("bus_stable", g, 16'(bus_now),    16'(prev_bus));
        end
        if (rsp_valid[g]) rcnt++;
      end
      prev_cs  = ram_cs[g];
      prev_add = ram_add[g];
      prev_bus = bus_now;
    end
  end

  function automatic int rcnt_of(input int g);
    return (g == 0) ? mdl[0].rcnt : mdl[1].rcnt;
  endfunction

  task automatic wait_ready(input int g);
    int k = 0;
    while (!req_ready[g] && k < 40) begin @(posedge clk); #2; k++; end
    check("ready_timeout", g, 16'(k >= 40), 16'd0);
  endtask

  // One access; exp_lat is the hand-computed cycle index of rsp_valid after
  // the handshake edge (also the number of cycles req_ready stays low).
  task automatic do_req(input int g, input logic we, input logic [11:0] a, input logic [3:0] d,
                        input int exp_lat, input logic [3:0] exp_rd);
    int n = 1, lat = 0, busy = 0, csn = 0;
    logic [3:0] rd = 4'h0;
    @(posedge clk); #2;
    req_valid[g] = 1'b1; req_we[g] = we; req_addr[g] = a; req_wdata[g] = d;
    wait_ready(g);
    @(posedge clk); #2;
    req_valid[g] = 1'b0; req_we[g] = ~we; req_addr[g] = ~a; req_wdata[g] = ~d;
    while (n < 40) begin
      if (ram_cs[g]) csn++;
      if (rsp_valid[g] && lat == 0) begin lat = n; rd = rsp_rdata[g]; end
      if (req_ready[g]) break;
      busy++;
      @(posedge clk); #2; n++;
    end
    check("latency",  g, 16'(lat),  16'(exp_lat));
    check("busy_len", g, 16'(busy), 16'(exp_lat));
    check("cs_len",   g, 16'(csn),  16'(exp_lat - 2));
    if (!we) check("read_val", g, 16'(rd), 16'(exp_rd));
  endtask

  // Ten requests with req_valid held high; alternating write / read-back.
  task automatic b2b(input int g, input int spacing);
    int r0, prev = 0;
    r0 = rcnt_of(g);
    @(posedge clk); #2;
    req_valid[g] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_we[g]    = (i % 2 == 0);
      req_addr[g]  = 12'(12'h200 + i / 2);
      req_wdata[g] = 4'(i + 1);
      wait_ready(g);
      @(posedge clk); #2;
      if (i > 0) check("hs_spacing", g, 16'(cyc - prev), 16'(spacing));
      prev = cyc;
    end
    req_valid[g] = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("b2b_rsp_cnt", g, 16'(rcnt_of(g) - r0), 16'd10);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      reset_n[g] = 1'b0; req_valid[g] = 1'b0; req_we[g] = 1'b0;
      req_addr[g] = 12'd0; req_wdata[g] = 4'd0;
    end
    @(posedge clk); #2;
    for (int g = 0; g < 2; g++) begin
      check("rst_cs",    g, 16'(ram_cs[g]),    16'd0);
      check("rst_we",    g, 16'(ram_we[g]),    16'd0);
      check("rst_add",   g, 16'(ram_add[g]),   16'd0);
      check("rst_rsp",   g, 16'(rsp_valid[g]), 16'd0);
      check("rst_rdata", g, 16'(rsp_rdata[g]), 16'd0);
      check("rst_ready", g, 16'(req_ready[g]), 16'd0);
    end
    @(posedge clk); #2;
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;
    #1;
    check("ready_after_rst", 0, 16'(req_ready[0]), 16'd1);
    check("ready_after_rst", 1, 16'(req_ready[1]), 16'd1);

    // STROBE_CYCLES = 1
    do_req(0, 1'b1, 12'h123, 4'hA, 3, 4'h0);
    do_req(0, 1'b0, 12'h123, 4'h0, 3, 4'hA);
    do_req(0, 1'b1, 12'hFFF, 4'h5, 3, 4'h0);
    do_req(0, 1'b1, 12'h000, 4'h3, 3, 4'h0);
    do_req(0, 1'b0, 12'hFFF, 4'h0, 3, 4'h5);
    do_req(0, 1'b0, 12'h000, 4'h0, 3, 4'h3);

    // STROBE_CYCLES = 4
    do_req(1, 1'b1, 12'h800, 4'h7, 6, 4'h0);
    do_req(1, 1'b0, 12'h800, 4'h0, 6, 4'h7);

    b2b(0, 4);
    b2b(1, 7);

    // Reset during the second strobe cycle of a write (STROBE_CYCLES = 4)
    begin
      int r0;
      r0 = rcnt_of(1);
      @(posedge clk); #2;
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 12'h456; req_wdata[1] = 4'h9;
      wait_ready(1);
      @(posedge clk); #2;
      req_valid[1] = 1'b0;
      @(posedge clk); #2;
      @(posedge clk); #2;
      check("abort_cs_before", 1, 16'(ram_cs[1]), 16'd1);
      reset_n[1] = 1'b0;
      @(posedge clk); #2;
      check("abort_cs",    1, 16'(ram_cs[1]),    16'd0);
      check("abort_rsp",   1, 16'(rsp_valid[1]), 16'd0);
      check("abort_ready", 1, 16'(req_ready[1]), 16'd0);
      check("abort_bus",   1, 16'(bus1),         16'h0);
      reset_n[1] = 1'b1;
      #1;
      check("abort_ready_rel", 1, 16'(req_ready[1]), 16'd1);
      repeat (10) @(posedge clk);
      #2;
      check("abort_no_rsp", 1, 16'(rcnt_of(1) - r0), 16'd0);
    end

    do_req(1, 1'b0, 12'h800, 4'h0, 6, 4'h7);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_bus_ctrl.md
RAM_BUS_CTRL -- requirements
Module: ram_bus_ctrl

Interface
REQ-001 Parameter STROBE_CYCLES, default 1: number of cycles ram_cs is held asserted per access (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_ready  output  1  controller can accept a request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  12  word address, 0..4095.
REQ-008 req_wdata  input  4  write nibble.
REQ-009 rsp_valid  output  1  one-cycle completion pulse (reads and writes).
REQ-010 rsp_rdata  output  4  read nibble; valid when rsp_valid=1 for a read.
REQ-011 ram_add  output  12  address to the 4096x4 RAM.
REQ-012 ram_we  output  1  RAM write enable, active-high.
REQ-013 ram_cs  output  1  RAM chip select, active-high.
REQ-014 ram_data  inout  4  shared RAM data bus; driven by this block only during write phases, else 4'bzzzz.

Function
REQ-015 States SHALL be IDLE, SETUP, STROBE, HOLD; encoding free.
REQ-016 req_ready SHALL be 1 only in IDLE; handshake occurs when req_valid=1 and req_ready=1 on a rising edge.
REQ-017 On handshake, the controller SHALL latch req_we, req_addr, req_wdata and go to SETUP; core inputs are don't-care thereafter.
REQ-018 IDLE with no handshake: stay in IDLE; ram_cs=0, ram_we=0, ram_data=z, ram_add holds last value.
REQ-019 SETUP (1 cycle): ram_add = latched address, ram_cs=0, ram_we=0; for writes ram_data = latched wdata; next STROBE.
REQ-020 STROBE (STROBE_CYCLES cycles, 4-bit down-counter): ram_cs=1, ram_we = latched we; writes drive ram_data; reads leave ram_data=z.
REQ-021 On the last STROBE cycle of a read, ram_data SHALL be sampled into rsp_rdata at that rising edge.
REQ-022 HOLD (1 cycle): ram_cs=0, ram_we=0, ram_add unchanged, writes still drive ram_data; rsp_valid=1; next IDLE.
REQ-023 ram_add and ram_data SHALL never change while ram_cs=1; ram_we SHALL never be 1 while ram_cs=0.
REQ-024 Access latency: handshake at edge T -> rsp_valid high during cycle T+2+STROBE_CYCLES; next handshake possible at T+3+STROBE_CYCLES.
REQ-025 rsp_rdata SHALL hold its value until the next read completes; writes do not alter it.
REQ-026 rsp_valid SHALL be asserted for exactly one cycle per accepted request and never otherwise.
REQ-027 Address 4095 and 0 SHALL be handled identically to any other address; no wrap or increment logic.
REQ-028 req_valid deasserted mid-access SHALL have no effect; the access completes.

Reset
REQ-029 With reset_n=0 at a rising edge: state=IDLE, counter=0, ram_cs=0, ram_we=0, ram_add=0, rsp_valid=0, rsp_rdata=0, ram_data=z, req_ready=0 during the reset cycle.
REQ-030 Reset during SETUP/STROBE/HOLD SHALL abort the access: no rsp_valid, ram_cs dropped at that edge, a partially strobed write is not retried.
REQ-031 First handshake possible on the first edge after reset_n returns to 1.

Verification
REQ-032 Write 0xA to 0x123, STROBE_CYCLES=1 -> ram_cs high exactly 1 cycle with ram_we=1, ram_add=0x123, ram_data=0xA; rsp_valid at T+3.
REQ-033 Read back 0x123 -> ram_data z from controller, rsp_rdata=0xA with rsp_valid at T+3; write 0x5 to 0xFFF and 0x3 to 0x000, read both -> 0x5, 0x3.
REQ-034 STROBE_CYCLES=4, write then read 0x7 at 0x800 -> ram_cs high 4 cycles each, rsp_valid at T+6, req_ready low T+1..T+6.
REQ-035 req_valid held high for 10 requests back-to-back -> handshakes spaced STROBE_CYCLES+3 cycles, 10 rsp_valid pulses, no bus contention (no X on ram_data).
REQ-036 reset_n=0 in second STROBE cycle of a write (STROBE_CYCLES=4) -> ram_cs=0, ram_data=z, rsp_valid never asserted, req_ready=1 one cycle after release.
REQ-037 Assertion monitor throughout: REQ-023 and REQ-026 never violated.
